// File: rtl/arm_mem_pkg.sv
// Shared definitions for the data-memory path: controller state encoding,
// default data-window base address and external SRAM data width.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned BASE_ADDR_DEFAULT = 1024;
  localparam int unsigned SRAM_DW           = 16;

endpackage

// File: rtl/sram_ctrl.sv
// Data-memory controller: serves each 32-bit MEM-stage load/store as two
// 16-bit phases on an external asynchronous SRAM (low half first), holding
// ready low while the access is in flight so the pipeline freezes.
module sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  output logic [SRAM_DW-1:0]     sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DW-1:0]     sram_dq_in
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned WRD_W = SRAM_ADDR_W - 1;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [WRD_W-1:0]   word_q;
  logic [31:0]        wdata_q;
  logic               is_wr_q;
  logic [SRAM_DW-1:0] lo_q;

  logic               req;
  logic               last;
  logic [31:0]        offset;
  logic [WRD_W-1:0]   word_in;
  logic               unused_bits;

  assign req         = wr_en | rd_en;
  assign last        = (cnt == CNT_W'(WAIT_CYCLES - 1));
  // Out-of-window addresses wrap modulo the SRAM size; byte offset is ignored.
  assign offset      = address - 32'(BASE_ADDR);
  assign word_in     = offset[SRAM_ADDR_W:2];
  assign unused_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

  // State, wait counter, latched request and read-halfword assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      word_q    <= '0;
      wdata_q   <= '0;
      is_wr_q   <= 1'b0;
      lo_q      <= '0;
      read_data <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (state == ST_IDLE && req) begin
        word_q  <= word_in;
        wdata_q <= write_data;
        is_wr_q <= wr_en;
      end
      if (state == ST_LO && last && !is_wr_q) lo_q <= sram_dq_in;
      // Full word is published on entry to DONE so it is valid while ready is high.
      if (state == ST_HI && last && !is_wr_q) read_data <= {sram_dq_in, lo_q};
    end
  end

  // Next-state logic and SRAM pin / ready decoding.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_we_n   = 1'b1;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = ~req;
        if (req) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end
      end
      ST_LO: begin
        sram_addr = {word_q, 1'b0};
        if (is_wr_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[15:0];
        end
        if (last) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_HI: begin
        sram_addr = {word_q, 1'b1};
        if (is_wr_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[31:16];
        end
        if (last) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_DONE: begin
        ready   = 1'b1;
        // Unconditional return: the finishing instruction's request is still high here.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural 16-bit SRAM on the pins, a word-level
// reference memory, and a scoreboard checked by an independent monitor.
module tb_sram_ctrl;

  localparam int unsigned AW    = 18;
  localparam int unsigned WAITC = 2;
  localparam int unsigned LAT   = 2 * WAITC + 1;
  localparam int unsigned NWORD = 1 << (AW - 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rd_en;
  logic [31:0]   address, write_data;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic          sram_we_n;
  logic [15:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic [15:0]   sram_dq_in;

  int checks = 0;
  int errors = 0;
  int issued = 0;
  int completed = 0;

  typedef struct {
    bit          is_wr;
    logic [31:0] data;
    int unsigned widx;
  } exp_t;

  exp_t sb[$];

  logic [15:0] mem [0:(1<<AW)-1];
  logic [15:0] ref_hw [int unsigned];

  sram_ctrl #(.BASE_ADDR(1024), .SRAM_ADDR_W(AW), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_we_n(sram_we_n),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: read follows address, write commits while we_n is low.
  assign sram_dq_in = mem[sram_addr];
  always @(posedge clk) if (sram_we_n === 1'b0) mem[sram_addr] <= sram_dq_out;

  function automatic logic [15:0] init_hw(input int unsigned i);
    return 16'(i * 40503 + 7);
  endfunction

  function automatic int unsigned wordidx(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'(off / 4) % NWORD;
  endfunction

  function automatic logic [15:0] get_hw(input int unsigned i);
    return ref_hw.exists(i) ? ref_hw[i] : init_hw(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Issue one access at #1 after a rising edge; returns #1 after the edge leaving DONE.
  task automatic access(input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input bit keep);
    exp_t e;
    bit   seen;
    wr_en = w; rd_en = r; address = a; write_data = d;
    e.is_wr = w;
    e.widx  = wordidx(a);
    if (w) begin
      e.data = d;
      ref_hw[2*e.widx]   = d[15:0];
      ref_hw[2*e.widx+1] = d[31:16];
    end else begin
      e.data = {get_hw(2*e.widx+1), get_hw(2*e.widx)};
    end
    sb.push_back(e);
    issued++;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin seen = 1'b1; break; end
    end
    if (!seen) chk("ready_timeout", 32'(ready), 32'd1);
    @(posedge clk); #1;
    if (!keep) begin wr_en = 1'b0; rd_en = 1'b0; end
  endtask

  // Monitor: measures each access from ready falling to ready rising and scores it.
  int low_cnt = 0, wen_cnt = 0, oe_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b0) begin
      low_cnt = 0; wen_cnt = 0; oe_cnt = 0;
    end else if (ready === 1'b0) begin
      low_cnt++;
      if (sram_we_n === 1'b0) wen_cnt++;
      if (sram_dq_oe === 1'b1) oe_cnt++;
    end else begin
      if (low_cnt > 0) begin
        if (sb.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          completed++;
          chk("latency", 32'(low_cnt), 32'(LAT));
          if (e.is_wr) begin
            chk("we_low_cycles", 32'(wen_cnt), 32'(2 * WAITC));
            chk("oe_cycles", 32'(oe_cnt), 32'(2 * WAITC));
            chk("sram_lo", 32'(mem[2*e.widx]), 32'(e.data[15:0]));
            chk("sram_hi", 32'(mem[2*e.widx+1]), 32'(e.data[31:16]));
          end else begin
            chk("read_data", read_data, e.data);
            chk("rd_oe_cycles", 32'(oe_cnt), 32'd0);
            chk("rd_we_cycles", 32'(wen_cnt), 32'd0);
          end
        end
      end
      low_cnt = 0; wen_cnt = 0; oe_cnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [1:0]    op;
    logic [31:0] a;
    int unsigned gap;

    for (int i = 0; i < (1 << AW); i++) mem[i] = init_hw(i);
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;

    @(posedge clk);
    @(negedge clk);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;

    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
    chk("store_sram0", 32'(mem[0]), 32'h0000BEEF);
    chk("store_sram1", 32'(mem[1]), 32'h0000DEAD);
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'd1030, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'd1020, 32'h12345678, 1'b0);
    chk("wrap_top_lo", 32'(mem[18'h3FFFE]), 32'h00005678);
    chk("wrap_top_hi", 32'(mem[18'h3FFFF]), 32'h00001234);
    access(1'b0, 1'b1, 32'd1020, 32'h0, 1'b0);

    // Back-to-back: request held through DONE, new request immediately after.
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1);
    access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    @(negedge clk);
    chk("b2b_count", 32'(completed), 32'(issued));
    @(posedge clk); #1;

    // Both enables: treated as a store.
    access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b0);
    access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);

    // Reset during the high phase of a load (not scoreboarded: it never completes).
    rd_en = 1'b1; address = 32'd1036;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; rd_en = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_read_data", read_data, 32'd0);
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_oe", 32'(sram_dq_oe), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    access(1'b0, 1'b1, 32'd1036, 32'h0, 1'b0);

    // Randomised traffic.
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) < 7)
        a = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      else
        a = $urandom;
      access(op != 2'd0, op != 2'd1, a, $urandom, ($urandom_range(0, 1) == 1) && (n != 39));
      if (wr_en === 1'b0 && rd_en === 1'b0) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < int'(gap); g++) begin
          @(negedge clk);
          chk("gap_ready", 32'(ready), 32'd1);
          @(posedge clk); #1;
        end
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("completions", 32'(completed), 32'(issued));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
